// File: rtl/lif_timestep_scheduler.sv
// Timestep scheduler for a shared LIF potential adder: walks every neuron once per
// timestep, fetching its weight, updating its stored potential and emitting spike events.
module lif_timestep_scheduler #(
    parameter int NUM_NEURONS = 16,
    parameter int ID_W        = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_ts_start,
    output logic            o_busy,
    output logic            o_ts_done,
    output logic [ID_W:0]   o_spike_count,
    output logic            o_wt_req,
    output logic [ID_W-1:0] o_wt_idx,
    input  logic [31:0]     i_wt_data,
    input  logic            i_wt_valid,
    output logic [31:0]     o_adder_weight,
    output logic [31:0]     o_adder_potential,
    output logic            o_adder_set,
    output logic            o_adder_clear,
    input  logic [31:0]     i_adder_final,
    input  logic            i_adder_spike,
    output logic            o_spike_valid,
    output logic [ID_W-1:0] o_spike_id,
    input  logic            i_spike_ready,
    input  logic [ID_W-1:0] i_dbg_idx,
    output logic [31:0]     o_dbg_pot
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG,
        S_FETCH,
        S_ADD,
        S_EMIT,
        S_DONE
    } state_t;

    localparam logic [ID_W-1:0] LAST_IDX = ID_W'(NUM_NEURONS - 1);

    state_t          r_state;
    logic [ID_W-1:0] r_idx;
    logic [ID_W:0]   r_count;
    logic [31:0]     r_pot [NUM_NEURONS];

    logic            w_last;
    logic [ID_W-1:0] w_next_idx;
    logic [ID_W:0]   w_count_inc;

    assign w_last      = (r_idx == LAST_IDX);
    assign w_next_idx  = r_idx + ID_W'(1);
    // The counter saturates so a wide timestep can never wrap back to a small count.
    assign w_count_inc = (r_count == '1) ? r_count : r_count + (ID_W + 1)'(1);

    assign o_dbg_pot = (i_dbg_idx <= LAST_IDX) ? r_pot[i_dbg_idx] : '0;

    // Outputs are registered, so each transition loads the values the next state presents.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state           <= S_IDLE;
            r_idx             <= '0;
            r_count           <= '0;
            o_busy            <= 1'b0;
            o_ts_done         <= 1'b0;
            o_spike_count     <= '0;
            o_wt_req          <= 1'b0;
            o_wt_idx          <= '0;
            o_adder_weight    <= '0;
            o_adder_potential <= '0;
            o_adder_set       <= 1'b0;
            o_adder_clear     <= 1'b1;
            o_spike_valid     <= 1'b0;
            o_spike_id        <= '0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                r_pot[i] <= '0;
            end
        end else begin
            o_ts_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_ts_start) begin
                        r_idx         <= '0;
                        r_count       <= '0;
                        o_busy        <= 1'b1;
                        o_adder_set   <= 1'b1;
                        o_adder_clear <= 1'b0;
                        r_state       <= S_CFG;
                    end
                end
                S_CFG: begin
                    o_adder_set   <= 1'b0;
                    o_adder_clear <= 1'b1;
                    o_wt_req      <= 1'b1;
                    o_wt_idx      <= r_idx;
                    r_state       <= S_FETCH;
                end
                S_FETCH: begin
                    if (i_wt_valid) begin
                        o_adder_weight    <= i_wt_data;
                        o_adder_potential <= r_pot[r_idx];
                        o_wt_req          <= 1'b0;
                        o_adder_clear     <= 1'b0;
                        r_state           <= S_ADD;
                    end
                end
                S_ADD: begin
                    r_pot[r_idx]  <= i_adder_final;
                    o_adder_clear <= 1'b1;
                    if (i_adder_spike) begin
                        r_count       <= w_count_inc;
                        o_spike_valid <= 1'b1;
                        o_spike_id    <= r_idx;
                        r_state       <= S_EMIT;
                    end else if (w_last) begin
                        o_ts_done     <= 1'b1;
                        o_spike_count <= r_count;
                        r_state       <= S_DONE;
                    end else begin
                        r_idx    <= w_next_idx;
                        o_wt_req <= 1'b1;
                        o_wt_idx <= w_next_idx;
                        r_state  <= S_FETCH;
                    end
                end
                S_EMIT: begin
                    if (i_spike_ready) begin
                        o_spike_valid <= 1'b0;
                        if (w_last) begin
                            o_ts_done     <= 1'b1;
                            o_spike_count <= r_count;
                            r_state       <= S_DONE;
                        end else begin
                            r_idx    <= w_next_idx;
                            o_wt_req <= 1'b1;
                            o_wt_idx <= w_next_idx;
                            r_state  <= S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    o_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lif_timestep_scheduler.sv
// Bench for lif_timestep_scheduler: a behavioural float adder (threshold 200.0, reset by
// subtraction) plus a spike-id scoreboard filled when each timestep is launched.
module tb_lif_timestep_scheduler;

    localparam int N   = 16;
    localparam int IDW = 4;
    localparam logic [31:0] W150 = 32'h43160000;
    localparam logic [31:0] W250 = 32'h437A0000;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            tsStart = 1'b0;
    logic            busy;
    logic            tsDone;
    logic [IDW:0]    spikeCount;
    logic            wtReq;
    logic [IDW-1:0]  wtIdx;
    logic [31:0]     wtData;
    logic            wtValid = 1'b1;
    logic [31:0]     adderWeight;
    logic [31:0]     adderPotential;
    logic            adderSet;
    logic            adderClear;
    logic [31:0]     adderFinal;
    logic            adderSpike;
    logic            spikeValid;
    logic [IDW-1:0]  spikeId;
    logic            spikeReady = 1'b1;
    logic [IDW-1:0]  dbgIdx = '0;
    logic [31:0]     dbgPot;

    int tests = 0;
    int fails = 0;
    real expPot [N];
    int expQ [$];
    logic [31:0] curWeight = W150;
    int stallIdx = -1;
    int stallLeft = 0;
    int readyHold = 0;
    int readyBlockId = -1;
    int doneSeen = 0;
    int wtHoldChecks = 0;
    int spikeHoldChecks = 0;
    int popped;
    logic prevValidStall = 1'b0;
    logic prevWtStall = 1'b0;
    logic [IDW-1:0] prevId = '0;
    logic [IDW-1:0] prevWtIdx = '0;
    real sumR;

    assign wtData = curWeight;

    always #5 clk = ~clk;

    lif_timestep_scheduler #(.NUM_NEURONS(N), .ID_W(IDW)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_ts_start(tsStart),
        .o_busy(busy),
        .o_ts_done(tsDone),
        .o_spike_count(spikeCount),
        .o_wt_req(wtReq),
        .o_wt_idx(wtIdx),
        .i_wt_data(wtData),
        .i_wt_valid(wtValid),
        .o_adder_weight(adderWeight),
        .o_adder_potential(adderPotential),
        .o_adder_set(adderSet),
        .o_adder_clear(adderClear),
        .i_adder_final(adderFinal),
        .i_adder_spike(adderSpike),
        .o_spike_valid(spikeValid),
        .o_spike_id(spikeId),
        .i_spike_ready(spikeReady),
        .i_dbg_idx(dbgIdx),
        .o_dbg_pot(dbgPot)
    );

    function automatic real f2r(input logic [31:0] f);
        logic [10:0] e;
        if (f[30:23] == 8'd0) return 0.0;
        e = {3'b000, f[30:23]} + 11'd896;
        return $bitstoreal({f[31], e, f[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        if (d[62:52] == 11'd0) return {d[63], 31'd0};
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    // Behavioural adder: spikes above 200.0 and subtracts the threshold.
    always_comb begin
        sumR       = f2r(adderWeight) + f2r(adderPotential);
        adderSpike = 1'b0;
        adderFinal = r2f(sumR);
        if (!adderClear && !adderSet && sumR > 200.0) begin
            adderSpike = 1'b1;
            adderFinal = r2f(sumR - 200.0);
        end
    end

    // Upstream/downstream drivers, updated just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (wtReq && int'(wtIdx) == stallIdx && stallLeft > 0) begin
                wtValid = 1'b0;
                stallLeft--;
            end else begin
                wtValid = 1'b1;
            end
            spikeReady = !(spikeValid && (readyHold > 0 || int'(spikeId) == readyBlockId));
            if (spikeValid && readyHold > 0) readyHold--;
        end
    end

    // Monitor: scoreboard pops on handshakes and hold checks during stalls.
    always @(negedge clk) begin
        if (rst) begin
            prevValidStall = 1'b0;
            prevWtStall    = 1'b0;
        end else begin
            if (prevWtStall) begin
                wtHoldChecks++;
                tests++;
                if (wtReq !== 1'b1 || wtIdx !== prevWtIdx) begin
                    fails++;
                    $display("[TB] FAIL wt_hold: got req=%b idx=%0d, expected req=1 idx=%0d", wtReq, wtIdx, prevWtIdx);
                end
            end
            if (prevValidStall) begin
                spikeHoldChecks++;
                tests++;
                if (spikeValid !== 1'b1 || spikeId !== prevId) begin
                    fails++;
                    $display("[TB] FAIL spike_hold: got valid=%b id=%0d, expected valid=1 id=%0d", spikeValid, spikeId, prevId);
                end
            end
            if (spikeValid && spikeReady) begin
                tests++;
                if (expQ.size() == 0) begin
                    fails++;
                    $display("[TB] FAIL spike_event: got unexpected id=%0d, expected no spike", spikeId);
                end else begin
                    popped = expQ.pop_front();
                    if (int'(spikeId) != popped) begin
                        fails++;
                        $display("[TB] FAIL spike_id: got %0d, expected %0d", spikeId, popped);
                    end
                end
            end
            if (tsDone) doneSeen++;
            prevWtStall    = wtReq && !wtValid;
            prevWtIdx      = wtIdx;
            prevValidStall = spikeValid && !spikeReady;
            prevId         = spikeId;
        end
    end

    // Launches one timestep after loading its expected spikes, then pulses ts_start in DONE.
    task automatic applyStimulus(input logic [31:0] w, output int cycles, output bit done,
                                 output logic [IDW:0] countAtDone, output logic busyAfter);
        real s;
        for (int i = 0; i < N; i++) begin
            s = expPot[i] + f2r(w);
            if (s > 200.0) begin
                expQ.push_back(i);
                expPot[i] = s - 200.0;
            end else begin
                expPot[i] = s;
            end
        end
        curWeight = w;
        @(posedge clk); #1; tsStart = 1'b1;
        @(posedge clk); #1; tsStart = 1'b0;
        cycles = 0;
        done = 1'b0;
        countAtDone = '0;
        busyAfter = 1'b1;
        while (!done && cycles < 400) begin
            @(negedge clk);
            cycles++;
            if (tsDone === 1'b1) done = 1'b1;
        end
        if (done) begin
            countAtDone = spikeCount;
            tsStart = 1'b1;
            @(posedge clk); #1; tsStart = 1'b0;
            @(negedge clk);
            busyAfter = busy;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < N; i++) expPot[i] = 0.0;
        expQ.delete();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            tests++;
            if (busy !== 1'b0) begin
                fails++;
                $display("[TB] FAIL idle_busy: got %b, expected 0", busy);
            end
        end
        tests++;
        if ({tsDone, wtReq, adderSet, spikeValid} !== 4'b0000) begin
            fails++;
            $display("[TB] FAIL reset_ctrl: got done/req/set/valid=%b, expected 0000", {tsDone, wtReq, adderSet, spikeValid});
        end
        tests++;
        if (adderClear !== 1'b1) begin
            fails++;
            $display("[TB] FAIL reset_clear: got %b, expected 1", adderClear);
        end
        tests++;
        if (wtIdx !== '0 || spikeId !== '0 || spikeCount !== '0) begin
            fails++;
            $display("[TB] FAIL reset_idx: got wt_idx=%0d spike_id=%0d count=%0d, expected 0 0 0", wtIdx, spikeId, spikeCount);
        end
        tests++;
        if (adderWeight !== 32'h0 || adderPotential !== 32'h0) begin
            fails++;
            $display("[TB] FAIL reset_adder: got w=%h p=%h, expected 0 0", adderWeight, adderPotential);
        end
        for (int i = 0; i < N; i++) begin
            dbgIdx = IDW'(i);
            #1;
            tests++;
            if (dbgPot !== 32'h0) begin
                fails++;
                $display("[TB] FAIL reset_pot[%0d]: got %h, expected 00000000", i, dbgPot);
            end
        end
    endtask

    task automatic test_no_spike();
        int cycles;
        bit done;
        logic [IDW:0] cnt;
        logic busyAfter;
        applyStimulus(W150, cycles, done, cnt, busyAfter);
        tests++;
        if (!done || cycles != 34) begin
            fails++;
            $display("[TB] FAIL nospike_len: got done=%0d cycles=%0d, expected done=1 cycles=34", done, cycles);
        end
        tests++;
        if (cnt !== '0) begin
            fails++;
            $display("[TB] FAIL nospike_count: got %0d, expected 0", cnt);
        end
        tests++;
        if (busyAfter !== 1'b0) begin
            fails++;
            $display("[TB] FAIL start_in_done: got busy=%b, expected 0", busyAfter);
        end
        for (int i = 0; i < N; i++) begin
            dbgIdx = IDW'(i);
            #1;
            tests++;
            if (dbgPot !== 32'h43160000) begin
                fails++;
                $display("[TB] FAIL nospike_pot[%0d]: got %h, expected 43160000", i, dbgPot);
            end
        end
    endtask

    task automatic test_spike();
        int cycles;
        bit done;
        logic [IDW:0] cnt;
        logic busyAfter;
        applyStimulus(W150, cycles, done, cnt, busyAfter);
        tests++;
        if (!done || cycles != 50) begin
            fails++;
            $display("[TB] FAIL spike_len: got done=%0d cycles=%0d, expected done=1 cycles=50", done, cycles);
        end
        tests++;
        if (cnt !== 5'd16) begin
            fails++;
            $display("[TB] FAIL spike_count: got %0d, expected 16", cnt);
        end
        tests++;
        if (expQ.size() != 0) begin
            fails++;
            $display("[TB] FAIL spike_lost: got %0d events missing, expected 0", expQ.size());
        end
        for (int i = 0; i < N; i++) begin
            dbgIdx = IDW'(i);
            #1;
            tests++;
            if (dbgPot !== 32'h42C80000) begin
                fails++;
                $display("[TB] FAIL spike_pot[%0d]: got %h, expected 42C80000", i, dbgPot);
            end
        end
    endtask

    task automatic test_backpressure();
        int cycles;
        bit done;
        logic [IDW:0] cnt;
        logic busyAfter;
        int wtBase;
        int spBase;
        wtBase = wtHoldChecks;
        spBase = spikeHoldChecks;
        stallIdx = 5;
        stallLeft = 3;
        readyHold = 4;
        applyStimulus(W150, cycles, done, cnt, busyAfter);
        stallIdx = -1;
        tests++;
        if (!done || cycles != 57) begin
            fails++;
            $display("[TB] FAIL bp_len: got done=%0d cycles=%0d, expected done=1 cycles=57", done, cycles);
        end
        tests++;
        if (wtHoldChecks - wtBase != 3 || spikeHoldChecks - spBase != 4) begin
            fails++;
            $display("[TB] FAIL bp_stalls: got wt=%0d spike=%0d, expected wt=3 spike=4", wtHoldChecks - wtBase, spikeHoldChecks - spBase);
        end
        tests++;
        if (cnt !== 5'd16 || expQ.size() != 0) begin
            fails++;
            $display("[TB] FAIL bp_events: got count=%0d missing=%0d, expected 16 0", cnt, expQ.size());
        end
        for (int i = 0; i < N; i++) begin
            dbgIdx = IDW'(i);
            #1;
            tests++;
            if (dbgPot !== 32'h42480000) begin
                fails++;
                $display("[TB] FAIL bp_pot[%0d]: got %h, expected 42480000", i, dbgPot);
            end
        end
    endtask

    task automatic test_abort();
        real s;
        int waitCnt;
        int doneBase;
        int idleBusy;
        for (int i = 0; i < N; i++) begin
            s = expPot[i] + f2r(W250);
            if (s > 200.0) expQ.push_back(i);
        end
        curWeight = W250;
        stallIdx = 3;
        stallLeft = 2;
        readyBlockId = 3;
        doneBase = doneSeen;
        @(posedge clk); #1; tsStart = 1'b1;
        @(posedge clk); #1; tsStart = 1'b0;
        waitCnt = 0;
        do begin
            @(negedge clk);
            waitCnt++;
        end while (!(wtReq && wtIdx == 4'd3) && waitCnt < 200);
        @(posedge clk); #1; tsStart = 1'b1;
        @(posedge clk); #1; tsStart = 1'b0;
        waitCnt = 0;
        do begin
            @(negedge clk);
            waitCnt++;
        end while (!(spikeValid && spikeId == 4'd3) && waitCnt < 200);
        tests++;
        if (waitCnt >= 200 || expQ.size() != 13 || expQ[0] != 3) begin
            fails++;
            $display("[TB] FAIL abort_progress: got pending=%0d wait=%0d, expected 13 events left starting at 3", expQ.size(), waitCnt);
        end
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        expQ.delete();
        for (int i = 0; i < N; i++) expPot[i] = 0.0;
        stallIdx = -1;
        readyBlockId = -1;
        curWeight = W150;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || spikeValid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL abort_state: got busy=%b valid=%b, expected 0 0", busy, spikeValid);
        end
        for (int i = 0; i < N; i++) begin
            dbgIdx = IDW'(i);
            #1;
            tests++;
            if (dbgPot !== 32'h0) begin
                fails++;
                $display("[TB] FAIL abort_pot[%0d]: got %h, expected 00000000", i, dbgPot);
            end
        end
        idleBusy = 0;
        repeat (40) begin
            @(negedge clk);
            if (busy) idleBusy++;
        end
        tests++;
        if (doneSeen != doneBase || idleBusy != 0) begin
            fails++;
            $display("[TB] FAIL abort_quiet: got ts_done=%0d busy_cycles=%0d, expected 0 0", doneSeen - doneBase, idleBusy);
        end
    endtask

    initial begin
        test_reset();
        test_no_spike();
        test_spike();
        test_backpressure();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
